// File: rtl/sonic_core.sv
// Sonic block-cipher core: iterative Feistel-like rounds, UNROLL rounds per clock.
// Optional output whitening with the final key register: define SONIC_WHITEN_EN.
module sonic_core #(
  parameter int BLOCK_W    = 64,
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = 16,
  parameter int UNROLL     = 1,
  parameter int PERM_MUL   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  localparam int H  = BLOCK_W / 2;
  localparam int CW = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  fsm_t               fsm;
  logic [BLOCK_W-1:0] st;
  logic [BLOCK_W-1:0] st_nx;
  logic [BLOCK_W-1:0] dout_nx;
  logic [KEY_W-1:0]   key;
  logic [KEY_W-1:0]   key_nx;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nx;
  logic               last;

  function automatic logic [H-1:0] rotl(
    input logic [H-1:0] v,
    input int           n
  );
    return (v << n) | (v >> (H - n));
  endfunction

  function automatic logic [KEY_W-1:0] key_rotr(
    input logic [KEY_W-1:0] k
  );
    logic [KEY_W-1:0] o;
    for (int i = 0; i < KEY_W; i++)
      o[i] = k[(i + H) % KEY_W];
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] sonic_round(
    input logic [BLOCK_W-1:0] s,
    input logic [H-1:0]       rk
  );
    logic [H-1:0] l;
    logic [H-1:0] r;
    logic [H-1:0] y;
    logic [H-1:0] t;
    logic [H-1:0] x;
    l = s[BLOCK_W-1:H];
    r = s[H-1:0];
    y = rotl(r, 1) ^ rotl(r, 8) ^ rotl(r, 10) ^ rk;
    t = l ^ (rotl(r, 12) & r) ^ rotl(r, 1);
    for (int i = 0; i < H; i++)
      x[i] = t[(PERM_MUL * i) % H];
    return {y, x};
  endfunction

  // Unrolled round chain; round index is cnt+u, key rotates after each round
  always_comb begin
    st_nx  = st;
    key_nx = key;
    for (int u = 0; u < UNROLL; u++) begin
      st_nx  = sonic_round(st_nx,
                 key_nx[H-1:0] ^ (H'(cnt) + H'(u + 1)));
      key_nx = key_rotr(key_nx);
    end
  end

  assign cnt_nx = cnt + CW'(UNROLL);
  assign last   = (cnt_nx == CW'(NUM_ROUNDS));

`ifdef SONIC_WHITEN_EN
  logic [BLOCK_W-1:0] wht;

  always_comb begin
    wht = '0;
    for (int i = 0; i < BLOCK_W; i++)
      wht[i] = key_nx[i % KEY_W];
  end

  assign dout_nx = st_nx ^ wht;
`else
  assign dout_nx = st_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      st        <= '0;
      key       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            st       <= in_data;
            key      <= in_key;
            cnt      <= '0;
            fsm      <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          st  <= st_nx;
          key <= key_nx;
          cnt <= cnt_nx;
          if (last) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
            out_data  <= dout_nx;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_core.sv
// Directed bench for sonic_core: one-round vectors, 16-round unrolled vs
// iterative builds against a reference model, back-pressure and reset.
module tb_sonic_core;

  logic         clk;
  logic         rst_n;
  logic [63:0]  in_data;
  logic [127:0] in_key;

  logic         iv_a, ir_a, ov_a, or_a, bz_a;
  logic [63:0]  od_a;
  logic         iv_b, ir_b, ov_b, or_b, bz_b;
  logic [63:0]  od_b;
  logic         iv_c, ir_c, ov_c, or_c, bz_c;
  logic [63:0]  od_c;

  int errors = 0;
  int checks = 0;

  sonic_core #(.NUM_ROUNDS(1), .UNROLL(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_a), .in_ready(ir_a),
    .in_data(in_data), .in_key(in_key),
    .out_valid(ov_a), .out_ready(or_a),
    .out_data(od_a), .busy(bz_a)
  );

  sonic_core #(.NUM_ROUNDS(16), .UNROLL(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_b), .in_ready(ir_b),
    .in_data(in_data), .in_key(in_key),
    .out_valid(ov_b), .out_ready(or_b),
    .out_data(od_b), .busy(bz_b)
  );

  sonic_core #(.NUM_ROUNDS(16), .UNROLL(4)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv_c), .in_ready(ir_c),
    .in_data(in_data), .in_key(in_key),
    .out_valid(ov_c), .out_ready(or_c),
    .out_data(od_c), .busy(bz_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    logic [63:0] dd;
    dd = {v, v};
    dd = dd << s;
    return dd[63:32];
  endfunction

  function automatic logic [63:0] model(
    input logic [63:0]  d,
    input logic [127:0] k,
    input int           n
  );
    logic [31:0] w [4];
    logic [31:0] l, r, y, t, x, rk;
    logic [63:0] o;
    for (int j = 0; j < 4; j++) w[j] = k[32*j +: 32];
    l = d[63:32];
    r = d[31:0];
    for (int rr = 0; rr < n; rr++) begin
      rk = w[rr % 4] ^ 32'(rr + 1);
      y  = rl(r, 1) ^ rl(r, 8) ^ rl(r, 10) ^ rk;
      t  = l ^ (rl(r, 12) & r) ^ rl(r, 1);
      for (int i = 0; i < 32; i++) x[i] = t[(15 * i) % 32];
      l = y;
      r = x;
    end
    o = {l, r};
`ifdef SONIC_WHITEN_EN
    o = o ^ {w[(n + 1) % 4], w[n % 4]};
`endif
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input string tag, input logic [63:0] d,
                       input logic [127:0] k, input logic [63:0] exp);
    in_data = d;
    in_key  = k;
    iv_a    = 1'b1;
    tick();
    iv_a = 1'b0;
    chk({tag, "_run_busy"}, 128'(bz_a), 128'(1));
    chk({tag, "_run_ready"}, 128'(ir_a), 128'(0));
    chk({tag, "_run_valid"}, 128'(ov_a), 128'(0));
    chk({tag, "_run_data"}, 128'(od_a), 128'(0));
    tick();
    chk({tag, "_valid"}, 128'(ov_a), 128'(1));
    chk({tag, "_data"}, 128'(od_a), 128'(exp));
    or_a = 1'b1;
    tick();
    or_a = 1'b0;
    chk({tag, "_post_valid"}, 128'(ov_a), 128'(0));
    chk({tag, "_post_ready"}, 128'(ir_a), 128'(1));
    chk({tag, "_post_data"}, 128'(od_a), 128'(0));
  endtask

  logic [63:0]  d1, d2, d3, exp_b, exp_c, exp_c2;
  logic [127:0] k1, k2, k3;
  int lat_b, lat_c, lat_c2;
  logic seen;

  initial begin
    rst_n   = 1'b0;
    in_data = '0;
    in_key  = '0;
    iv_a = 0; or_a = 0;
    iv_b = 0; or_b = 0;
    iv_c = 0; or_c = 0;
    #3;
    chk("rst_valid", 128'(ov_a), 128'(0));
    chk("rst_busy", 128'(bz_b), 128'(0));
    chk("rst_data", 128'(od_c), 128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 128'({ir_a, ir_b, ir_c}), 128'(3'b111));

    // one-round vectors
    run_a("zero", 64'h0, 128'h0, 64'h00000001_00000000);
    run_a("lhi", 64'hFFFFFFFF_00000000, 128'h0, 64'h00000001_FFFFFFFF);
    k1 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    run_a("keyed", 64'h01234567_89abcdef, k1,
          model(64'h01234567_89abcdef, k1, 1));

    // 16 rounds, iterative vs unrolled-by-4
    d1 = {$urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom, $urandom};
    exp_b = model(d1, k1, 16);
    in_data = d1;
    in_key  = k1;
    iv_b = 1'b1;
    iv_c = 1'b1;
    lat_b = 0;
    lat_c = 0;
    @(posedge clk);
    #1;
    iv_b = 1'b0;
    iv_c = 1'b0;
    in_data = ~d1;
    in_key  = ~k1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (ov_b && lat_b == 0) lat_b = k;
      if (ov_c && lat_c == 0) lat_c = k;
    end
    chk("lat_u1", 128'(lat_b), 128'(16));
    chk("lat_u4", 128'(lat_c), 128'(4));
    chk("data_u1", 128'(od_b), 128'(exp_b));
    chk("data_u4", 128'(od_c), 128'(exp_b));

    // back-pressure: output held, new requests ignored
    for (int k = 0; k < 10; k++) begin
      iv_c    = k[0];
      in_data = {$urandom, $urandom};
      tick();
      chk("hold_data", 128'(od_c), 128'(exp_b));
      chk("hold_ctl", 128'({ov_c, ir_c, bz_c}), 128'(3'b101));
    end
    d2 = 64'hdeadbeef_cafef00d;
    k2 = 128'h00112233_44556677_8899aabb_ccddeeff;
    exp_c2 = model(d2, k2, 16);
    in_data = d2;
    in_key  = k2;
    iv_c = 1'b1;
    or_b = 1'b1;
    or_c = 1'b1;
    tick();
    or_b = 1'b0;
    or_c = 1'b0;
    chk("hs_ctl", 128'({ov_c, ir_c, bz_c}), 128'(3'b010));
    chk("hs_b", 128'({ov_b, ir_b, od_b}), 128'({1'b0, 1'b1, 64'h0}));
    tick();
    iv_c = 1'b0;
    chk("reacc_ctl", 128'({ir_c, bz_c}), 128'(2'b01));
    lat_c2 = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ov_c && lat_c2 == 0) lat_c2 = k;
    end
    chk("lat2_u4", 128'(lat_c2), 128'(4));
    chk("data2_u4", 128'(od_c), 128'(exp_c2));
    or_c = 1'b1;
    tick();
    or_c = 1'b0;

    // reset with b mid-run and c done
    d3 = {$urandom, $urandom};
    k3 = {$urandom, $urandom, $urandom, $urandom};
    in_data = d3;
    in_key  = k3;
    iv_b = 1'b1;
    iv_c = 1'b1;
    tick();
    iv_b = 1'b0;
    iv_c = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_rst", 128'({ov_c, bz_b, ov_b}), 128'(3'b110));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_c", 128'({ov_c, bz_c, od_c}), 128'(0));
    chk("arst_b", 128'({ov_b, bz_b, od_b}), 128'(0));
    #10;
    rst_n = 1'b1;
    tick();
    chk("arst_ready", 128'({ir_b, ir_c}), 128'(2'b11));
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ov_b || ov_c || bz_b || bz_c) seen = 1'b1;
    end
    chk("arst_quiet", 128'(seen), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sonic_core.md
SONIC_CORE -- requirements
Module: sonic_core

Interface
REQ-001 Parameter BLOCK_W, default 64, meaning: cipher state width in bits; legal values 64 or 128; half width H = BLOCK_W/2.
REQ-002 Parameter KEY_W, default 128, meaning: master key width in bits; SHALL be a multiple of H.
REQ-003 Parameter NUM_ROUNDS, default 16, meaning: total Sonic rounds per block, range 1..63.
REQ-004 Parameter UNROLL, default 1, meaning: rounds applied per clock; NUM_ROUNDS SHALL be divisible by UNROLL.
REQ-005 Parameter PERM_MUL, default 15, meaning: bit-permutation multiplier; SHALL be odd.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  plaintext and key present.
REQ-009 in_ready  out  1  core can accept a block.
REQ-010 in_data  in  BLOCK_W  plaintext; upper H bits = L, lower H bits = R.
REQ-011 in_key  in  KEY_W  master key for this block.
REQ-012 out_valid  out  1  out_data holds a finished ciphertext.
REQ-013 out_ready  in  1  consumer accepts out_data.
REQ-014 out_data  out  BLOCK_W  ciphertext.
REQ-015 busy  out  1  high in RUN or DONE.

Function
REQ-016 Round r (0-based) SHALL compute rk = key_reg[H-1:0] XOR (r+1) zero-extended to H bits.
REQ-017 Round SHALL compute y = rotl(R,1) ^ rotl(R,8) ^ rotl(R,10) ^ rk, with rotl by H-bit rotate-left.
REQ-018 Round SHALL compute t = L ^ (rotl(R,12) & R) ^ rotl(R,1).
REQ-019 Round SHALL compute x[i] = t[(PERM_MUL*i) mod H] for i = 0..H-1.
REQ-020 Round output SHALL be {y, x}; after each round key_reg SHALL rotate right by H bits.
REQ-021 FSM states: IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-022 IDLE, in_valid=1: SHALL load state <= in_data, key_reg <= in_key, round counter <= 0, go to RUN.
REQ-023 RUN: each cycle SHALL apply UNROLL consecutive rounds and advance counter by UNROLL; when counter reaches NUM_ROUNDS go to DONE.
REQ-024 Latency: out_valid SHALL rise exactly NUM_ROUNDS/UNROLL cycles after the accepting edge.
REQ-025 DONE: out_valid = 1, out_data stable until out_valid & out_ready; then go to IDLE (in_ready high next cycle).
REQ-026 No block overlap: a new block is accepted no earlier than the cycle after output handshake.
REQ-027 in_valid during RUN/DONE SHALL be ignored; in_data/in_key changes SHALL not affect an in-flight block.
REQ-028 out_data SHALL reflect the internal state only in DONE; it is 0 in IDLE and RUN.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, in_ready=1 after deassertion, out_valid=0, busy=0, out_data=0, state/key_reg/counter=0.
REQ-030 Reset during RUN or DONE SHALL discard the block; no out_valid follows.

Configuration
REQ-031 Macro SONIC_WHITEN_EN defined: DONE output SHALL be state XOR key_reg[BLOCK_W-1:0] (key_reg replicated when KEY_W < BLOCK_W) post-whitening; latency unchanged.
REQ-032 Macro SONIC_WHITEN_EN undefined: out_data SHALL be the raw final state; no whitening logic synthesised.

Verification (BLOCK_W=64, KEY_W=128, UNROLL=1, SONIC_WHITEN_EN undefined unless stated)
REQ-033 NUM_ROUNDS=1, in_data=0, in_key=0 -> out_valid 1 cycle after accept, out_data=64'h00000001_00000000.
REQ-034 NUM_ROUNDS=1, in_data=64'hFFFFFFFF_00000000, in_key=0 -> out_data=64'h00000001_FFFFFFFF.
REQ-035 NUM_ROUNDS=16, UNROLL=4, random data/key -> out_valid 4 cycles after accept; out_data equals UNROLL=1 build (16 cycles) and software model.
REQ-036 out_ready held 0 for 10 cycles in DONE, in_valid toggling -> out_data stable, in_ready 0, no second accept; accept next cycle after handshake.
REQ-037 rst_n pulsed low mid-RUN -> outputs zero asynchronously, in_ready=1 after release, no spurious out_valid.
REQ-038 SONIC_WHITEN_EN defined, NUM_ROUNDS=1, in_data=0, in_key=0 -> out_data=64'h00000001_00000000 (zero key whitening), latency 1.
